fibonacci_index: RTL

//   Inverse of the fibonacci generator: given a value, iteratively finds the

---
 rtl/fibonacci_index_if.sv | 24 ++
 rtl/fibonacci_index.sv | 91 +++++++++
 2 files changed

// File: rtl/fibonacci_index_if.sv
// Start/done handshake bundle for the Fibonacci index search.
// The master issues a value; the slave returns the index and flags.
interface fibonacci_index_if #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned VALUE_WIDTH = 2 * DATA_WIDTH + 2
);
    logic                   start;
    logic [VALUE_WIDTH-1:0] value;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  n;
    logic                   is_fib;
    logic                   ovf;

    modport master (
        output start, value,
        input  busy, done, n, is_fib, ovf
    );

    modport slave (
        input  start, value,
        output busy, done, n, is_fib, ovf
    );
endinterface

// File: rtl/fibonacci_index.sv
// Finds the smallest k with F(k) >= value by stepping (F(k), F(k+1)) one index per cycle.
// Reports exactness and overflow when no index in range reaches the value.
module fibonacci_index #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fibonacci_index_if.slave   bus
);
    localparam int unsigned VALUE_WIDTH = 2 * DATA_WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t                 state_q;
    logic [VALUE_WIDTH-1:0] v_q;
    // One extra bit so F(k+1) never wraps at the last index.
    logic [VALUE_WIDTH:0]   a_q;
    logic [VALUE_WIDTH:0]   b_q;
    logic [DATA_WIDTH-1:0]  k_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_WIDTH-1:0]  n_q;
    logic                   is_fib_q;
    logic                   ovf_q;

    logic [VALUE_WIDTH:0]   v_ext;
    assign v_ext = {1'b0, v_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            v_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            n_q      <= '0;
            is_fib_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        v_q     <= bus.value;
                        a_q     <= '0;
                        b_q     <= (VALUE_WIDTH + 1)'(1);
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    if (a_q >= v_ext) begin
                        n_q      <= k_q;
                        is_fib_q <= (a_q == v_ext);
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else if (k_q == {DATA_WIDTH{1'b1}}) begin
                        n_q      <= {DATA_WIDTH{1'b1}};
                        is_fib_q <= 1'b0;
                        ovf_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        a_q <= b_q;
                        b_q <= a_q + b_q;
                        k_q <= k_q + DATA_WIDTH'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.n      = n_q;
    assign bus.is_fib = is_fib_q;
    assign bus.ovf    = ovf_q;
endmodule
